// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the store buffer: funct3 codes, access sizing, entry layout.
package store_buffer_pkg;

    localparam int unsigned SB_DEPTH  = 4;
    localparam int unsigned SB_ADDR_W = 5;
    localparam int unsigned SB_DATA_W = 32;

    // Store widths
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    // Load widths
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [2:0]           funct3;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

    // Byte span of an access from the low two funct3 bits (byte/half/word).
    function automatic logic [2:0] size_of(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   size_of = 3'd1;
            2'b01:   size_of = 3'd2;
            default: size_of = 3'd4;
        endcase
    endfunction

    // Only sb/sh/sw are buffered; anything else is flagged and dropped.
    function automatic logic store_f3_ok(input logic [2:0] f3);
        store_f3_ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    endfunction

endpackage

// File: rtl/store_buffer_span_overlap.sv
// Combinational byte-range intersection test; ranges are extended by one bit so they never wrap.
module span_overlap #(
    parameter int unsigned AW = 5
) (
    input  logic [AW-1:0] a_addr_i,
    input  logic [2:0]    a_size_i,
    input  logic [AW-1:0] b_addr_i,
    input  logic [2:0]    b_size_i,
    output logic          overlap_o
);
    localparam int unsigned EW = AW + 1;

    logic [EW-1:0] a_lo, a_hi, b_lo, b_hi;

    // Inclusive [lo, hi] for each access; sizes are always at least one byte.
    always_comb begin
        a_lo      = EW'(a_addr_i);
        b_lo      = EW'(b_addr_i);
        a_hi      = a_lo + EW'(a_size_i) - EW'(1);
        b_hi      = b_lo + EW'(b_size_i) - EW'(1);
        overlap_o = (a_lo <= b_hi) && (b_lo <= a_hi);
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store FIFO in front of the single-port data memory; loads win the port unless they hit a buffered store.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = SB_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 st_valid,
    output logic                 st_ready,
    input  logic [SB_ADDR_W-1:0] st_addr,
    input  logic [2:0]           st_funct3,
    input  logic [SB_DATA_W-1:0] st_data,
    output logic                 st_err,
    input  logic                 ld_valid,
    input  logic [SB_ADDR_W-1:0] ld_addr,
    input  logic [2:0]           ld_funct3,
    output logic                 ld_stall,
    input  logic                 fence_req,
    output logic                 fence_done,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [SB_ADDR_W-1:0] mem_addr,
    output logic [SB_DATA_W-1:0] mem_wdata,
    output logic [2:0]           mem_funct3
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    sb_entry_t        entry_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             st_err_q, st_err_d;
    logic [DEPTH-1:0] hit;
    logic             push_hs, push_ok, pop;

    // One overlap comparator per entry against the presented load.
    for (genvar i = 0; i < DEPTH; i++) begin : g_ovl
        span_overlap #(.AW(SB_ADDR_W)) u_ovl (
            .a_addr_i  (entry_q[i].addr),
            .a_size_i  (size_of(entry_q[i].funct3[1:0])),
            .b_addr_i  (ld_addr),
            .b_size_i  (size_of(ld_funct3[1:0])),
            .overlap_o (hit[i])
        );
    end

    assign st_ready   = (count_q != CNT_W'(DEPTH));
    assign ld_stall   = ld_valid && |(valid_q & hit);
    assign fence_done = fence_req && (count_q == '0);
    assign st_err     = st_err_q;
    assign push_hs    = st_valid && st_ready;
    assign push_ok    = push_hs && store_f3_ok(st_funct3);
    assign pop        = mem_write;

    // Port arbitration: unstalled load first, else drain the head store.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_funct3 = '0;
        if (ld_valid && !ld_stall) begin
            mem_read   = 1'b1;
            mem_addr   = ld_addr;
            mem_funct3 = ld_funct3;
        end else if (count_q != '0) begin
            mem_write  = 1'b1;
            mem_addr   = entry_q[head_q].addr;
            mem_wdata  = entry_q[head_q].data;
            mem_funct3 = entry_q[head_q].funct3;
        end
    end

    // Pointer, occupancy and error next-state.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        valid_d  = valid_q;
        st_err_d = push_hs && !push_ok;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (push_ok) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state; reset empties the buffer and discards pending stores.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            st_err_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
            st_err_q <= st_err_d;
        end
    end

    // Entry payload storage; qualified by valid_q so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            entry_q[tail_q] <= '{addr: st_addr, funct3: st_funct3, data: st_data};
        end
    end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Small in-order FIFO that sits between the MEM stage and the byte-addressed data memory.
- Accepts sb/sh/sw requests, buffers them, and drains one per cycle to the memory's single address port.
- Loads take the port ahead of draining stores. Loads that overlap a buffered store are stalled until the overlap drains, so loads never return stale data.

Parameters:
DEPTH  4  number of buffered stores (power of two, >=2)
ADDR_W  5  byte-address width of data memory port
DATA_W  32  store data width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
st_valid  in  1  MEM stage presents a store
st_ready  out  1  buffer can accept (not full)
st_addr  in  ADDR_W  store byte address
st_funct3  in  3  000 sb, 001 sh, 010 sw
st_data  in  DATA_W  store data (low bytes used for sb/sh)
st_err  out  1  one-cycle pulse: accepted handshake had unsupported funct3
ld_valid  in  1  MEM stage presents a load
ld_addr  in  ADDR_W  load byte address
ld_funct3  in  3  load width code (000/100 byte, 001/101 half, 010 word)
ld_stall  out  1  load overlaps a buffered store; hold pipeline
fence_req  in  1  request full drain
fence_done  out  1  high when fence_req and buffer empty
mem_read  out  1  to data memory MemRead
mem_write  out  1  to data memory MemWrite
mem_addr  out  ADDR_W  to data memory addr
mem_wdata  out  DATA_W  to data memory data_in
mem_funct3  out  3  placed into inst[14:12] at data memory

Behaviour:
- Reset (async, any time): count=0, head=tail=0, all entry valid bits cleared, st_err=0. Combinational outputs evaluate from empty state: st_ready=1, ld_stall=0, mem_write=0, fence_done=fence_req. Stores in flight are discarded.
- Push: st_valid & st_ready at posedge writes {addr, funct3, data} at tail; tail wraps modulo DEPTH.
- Unsupported funct3 is not stored; st_err=1 the following cycle, otherwise 0.
- st_ready = (count != DEPTH). It is registered-state based: a push is refused while full even if a pop occurs in the same cycle.
- Byte span: sb=1, sh=2, sw=4. Load span uses the same sizes from ld_funct3[1:0].
- Overlap test: ranges [a, a+size-1], computed at ADDR_W+1 bits with no wrap, matching memory indexing past 31.
- ld_stall = ld_valid & (any valid entry overlaps load span). The test is against registered entries only; a store pushed in the same cycle does not stall that load.
- Port arbitration, combinational each cycle:
  - If ld_valid & ~ld_stall: mem_read=1, mem_addr=ld_addr, mem_funct3=ld_funct3, mem_write=0.
  - Else if count>0: mem_write=1, mem_addr/mem_wdata/mem_funct3 come from the head entry; the head pops at that posedge.
  - Else all mem_* = 0.
- mem_read and mem_write are never both 1.
- Count update: push only → +1; pop only → -1; both → unchanged.
- Latency: a store accepted at edge N is written no earlier than edge N+1. A lone store into an empty buffer with no load is written at N+1.
- Stalled load: the head drains during stall cycles, so the stall clears once the last overlapping entry has popped. The load then issues the next cycle.
- Drain order is strict FIFO. A later overlapping store never overtakes an earlier one.
- fence_done = fence_req & (count==0). No new-push blocking is implied; the pipeline holds off stores during fence.

Decomposition:
- Shared package: funct3 encodings (SB/SH/SW, LB/LH/LW/LBU/LHU), a size-from-funct3 function, and the store-entry struct {addr, funct3, data}.
- One natural sub-module: span_overlap (combinational; two addr/size pairs → overlap bit), instantiated DEPTH times.

Test Plan:
- Single sw addr=8 data=0x0000_00AA, no loads → mem_write=1 next cycle with addr 8, funct3 010, data 0xAA; count returns to 0.
- Push 4 stores back-to-back with ld_valid held on non-overlapping addr 20 → st_ready=0 after fourth push; mem_write stays 0 while load is held; drop load → 4 writes in push order over 4 cycles.
- sh addr=6 buffered, then lw addr=4 → ld_stall=1 until sh drains; next cycle mem_read=1 addr 4; memory word reflects new halfword.
- sb addr=3 buffered, lb addr=4 → ld_stall=0, load served immediately, store drains afterward.
- Full buffer, st_valid with funct3=011 → not accepted. Once space frees, accepted handshake with funct3=011 → st_err pulse, count unchanged, nothing written.
- Assert rst mid-drain with 3 entries → outputs immediately empty-state (mem_write=0, st_ready=1); none of the remaining stores reach memory; fence_req then gives fence_done=1 at once.
